am2951_ctl: RTL

Handshake controller that sequences one am2951 bidirectional mailbox port between an A-side host and a B-side host. It owns every port control strobe: `cer_`, `ces_`, `oea_`, `oeb_`, `clrr` and `clrs`. It arbitrates each side's bus between "host drives" (write) and "port drives" (read), and inserts turnaround cycles between the two. It sits beside the am2951. Both port clocks `cpr` and `cps` are tied to `cp`, so every strobe is a synchronous enable.

---
 rtl/am2951_ctl_pkg.sv | 29 ++
 rtl/am2951_side_fsm.sv | 119 +++++++++++
 rtl/am2951_ctl.sv | 77 +++++++
 3 files changed

// File: rtl/am2951_ctl_pkg.sv
// ============================================================================
// Module      : am2951_ctl_pkg
// Description : Shared types and constants for the am2951 mailbox controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package am2951_ctl_pkg;

    // Per-side sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_TURN = 3'd2,
        ST_RD   = 3'd3,
        ST_CLR  = 3'd4
    } side_st_t;

    // Width of the turnaround counter (TURN up to 3)
    localparam int TURN_W = 2;

    // Inactive levels of the port strobes
    localparam logic c_STB_OFF = 1'b1;   // cer_/ces_/oea_/oeb_ are active-low
    localparam logic c_CLR_OFF = 1'b0;   // clrr/clrs idle low
    localparam logic c_CLR_RST = 1'b1;   // clrr/clrs held high in reset to empty both flags

endpackage

`default_nettype wire

// File: rtl/am2951_side_fsm.sv
// ============================================================================
// Module      : am2951_side_fsm
// Description : One side of the am2951 mailbox handshake: writes its own
//               register, reads and clears the peer register, and keeps the
//               host bus and the port output enable mutually exclusive.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module am2951_side_fsm
    import am2951_ctl_pkg::*;
#(
    parameter int TURN     = 1,
    parameter int RD_FIRST = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_wr_req,
    input  logic i_rd_req,
    input  logic i_own_full,
    input  logic i_peer_full,
    output logic o_wr_n,
    output logic o_oe_n,
    output logic o_clr,
    output logic o_wr_ack,
    output logic o_rd_ack,
    output logic o_hdrv
);

    localparam logic [TURN_W-1:0] c_TURN_LOAD = TURN_W'((TURN > 0) ? TURN - 1 : 0);

    side_st_t            r_st;
    side_st_t            w_nxt_st;
    logic [TURN_W-1:0]   r_cnt;
    logic [TURN_W-1:0]   w_nxt_cnt;
    logic                w_wr_ok;
    logic                w_rd_ok;
    logic                w_take_rd;

    logic r_wr_n, r_oe_n, r_clr, r_wr_ack, r_rd_ack, r_hdrv;
    logic w_wr_n, w_oe_n, w_clr, w_wr_ack, w_rd_ack, w_hdrv;

    // Next-state selection plus decode of the strobes for the upcoming state
    always_comb begin
        w_nxt_st  = r_st;
        w_nxt_cnt = r_cnt;
        w_wr_ok   = i_wr_req && !i_own_full;
        w_rd_ok   = i_rd_req && i_peer_full;
        w_take_rd = w_rd_ok && ((RD_FIRST != 0) || !w_wr_ok);

        case (r_st)
            ST_IDLE: begin
                if (w_take_rd) begin
                    if (TURN > 0) begin
                        w_nxt_st  = ST_TURN;
                        w_nxt_cnt = c_TURN_LOAD;
                    end else begin
                        w_nxt_st  = ST_RD;
                    end
                end else if (w_wr_ok) begin
                    w_nxt_st = ST_WR;
                end
            end
            ST_WR:   w_nxt_st = ST_IDLE;
            ST_TURN: begin
                if (r_cnt == '0) begin
                    w_nxt_st = ST_RD;
                end else begin
                    w_nxt_cnt = r_cnt - 1'b1;
                end
            end
            ST_RD:   w_nxt_st = ST_CLR;
            ST_CLR:  w_nxt_st = ST_IDLE;
            default: w_nxt_st = ST_IDLE;
        endcase

        // Outputs are a pure function of the state being entered, so
        // registering them gives glitch-free strobes aligned to that state.
        w_wr_n   = (w_nxt_st == ST_WR) ? 1'b0 : c_STB_OFF;
        w_oe_n   = (w_nxt_st == ST_RD) ? 1'b0 : c_STB_OFF;
        w_clr    = (w_nxt_st == ST_CLR) ? 1'b1 : c_CLR_OFF;
        w_wr_ack = (w_nxt_st == ST_WR);
        w_rd_ack = (w_nxt_st == ST_RD);
        w_hdrv   = (w_nxt_st == ST_WR);
    end

    // State, counter and output registers; reset empties both mailboxes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st     <= ST_IDLE;
            r_cnt    <= '0;
            r_wr_n   <= c_STB_OFF;
            r_oe_n   <= c_STB_OFF;
            r_clr    <= c_CLR_RST;
            r_wr_ack <= 1'b0;
            r_rd_ack <= 1'b0;
            r_hdrv   <= 1'b0;
        end else begin
            r_st     <= w_nxt_st;
            r_cnt    <= w_nxt_cnt;
            r_wr_n   <= w_wr_n;
            r_oe_n   <= w_oe_n;
            r_clr    <= w_clr;
            r_wr_ack <= w_wr_ack;
            r_rd_ack <= w_rd_ack;
            r_hdrv   <= w_hdrv;
        end
    end

    assign o_wr_n   = r_wr_n;
    assign o_oe_n   = r_oe_n;
    assign o_clr    = r_clr;
    assign o_wr_ack = r_wr_ack;
    assign o_rd_ack = r_rd_ack;
    assign o_hdrv   = r_hdrv;

endmodule

`default_nettype wire

// File: rtl/am2951_ctl.sv
// ============================================================================
// Module      : am2951_ctl
// Description : Handshake controller for one am2951 bidirectional mailbox
//               port. A side writes R / reads S; B side writes S / reads R.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module am2951_ctl
    import am2951_ctl_pkg::*;
#(
    parameter int TURN     = 1,
    parameter int RD_FIRST = 1
) (
    input  logic cp,
    input  logic clr,
    input  logic fr,
    input  logic fs,
    input  logic a_wr_req,
    input  logic a_rd_req,
    output logic a_wr_ack,
    output logic a_rd_ack,
    output logic a_hdrv,
    input  logic b_wr_req,
    input  logic b_rd_req,
    output logic b_wr_ack,
    output logic b_rd_ack,
    output logic b_hdrv,
    output logic cer_,
    output logic oea_,
    output logic clrs,
    output logic ces_,
    output logic oeb_,
    output logic clrr
);

    // A side: writes R (full flag fr), reads and clears S (flag fs)
    am2951_side_fsm #(
        .TURN     (TURN),
        .RD_FIRST (RD_FIRST)
    ) u_side_a (
        .clk         (cp),
        .rst         (clr),
        .i_wr_req    (a_wr_req),
        .i_rd_req    (a_rd_req),
        .i_own_full  (fr),
        .i_peer_full (fs),
        .o_wr_n      (cer_),
        .o_oe_n      (oea_),
        .o_clr       (clrs),
        .o_wr_ack    (a_wr_ack),
        .o_rd_ack    (a_rd_ack),
        .o_hdrv      (a_hdrv)
    );

    // B side: writes S (full flag fs), reads and clears R (flag fr)
    am2951_side_fsm #(
        .TURN     (TURN),
        .RD_FIRST (RD_FIRST)
    ) u_side_b (
        .clk         (cp),
        .rst         (clr),
        .i_wr_req    (b_wr_req),
        .i_rd_req    (b_rd_req),
        .i_own_full  (fs),
        .i_peer_full (fr),
        .o_wr_n      (ces_),
        .o_oe_n      (oeb_),
        .o_clr       (clrr),
        .o_wr_ack    (b_wr_ack),
        .o_rd_ack    (b_rd_ack),
        .o_hdrv      (b_hdrv)
    );

endmodule

`default_nettype wire
